// File: rtl/frac_div_pkg.sv
// Shared types and helpers for the fractional clock-divider controller.
package frac_div_pkg;

    localparam int FD_CNT_W  = 8;
    localparam int FD_FRAC_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // A ratio N + F/D is usable only with N >= 2 and a proper fraction F < D.
    function automatic logic cfg_legal(input logic [31:0] n, input logic [31:0] f,
                                       input logic [31:0] d);
        return (n >= 32'd2) && (d >= 32'd1) && (f < d);
    endfunction

endpackage

// File: rtl/frac_div_core.sv
// Period core: cycle counter, duty comparator and registered div_clk.
// FRAC_DIV_HALF_DUTY_EN adds a negedge flop for exact 50% duty on odd lengths.
module frac_div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W:0]   len,
    output logic             div_clk,
    output logic             period_start,
    output logic             last_cycle
);

    logic [CNT_W:0] cnt;
    logic           pos_q;

    assign period_start = run && (cnt == '0);
    assign last_cycle   = run && (cnt == len - (CNT_W+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            pos_q <= 1'b0;
        end else begin
            if (load || last_cycle || !run)
                cnt <= '0;
            else
                cnt <= cnt + (CNT_W+1)'(1);
            // High for the first len>>1 counts, seen one clk later.
            pos_q <= run && (cnt < (len >> 1));
        end
    end

`ifdef FRAC_DIV_HALF_DUTY_EN
    logic neg_q;

    // Trails pos_q by half a cycle on odd lengths, stretching the high phase.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            neg_q <= 1'b0;
        else
            neg_q <= pos_q && len[0];
    end

    assign div_clk = pos_q | neg_q;
`else
    assign div_clk = pos_q;
`endif

endmodule

// File: rtl/frac_div_ctrl.sv
// Fractional clock-divider controller: N + F/D via a first-order accumulator.
// Optional macro FRAC_DIV_HALF_DUTY_EN selects exact 50% duty in the core.
module frac_div_ctrl
    import frac_div_pkg::*;
#(
    parameter int CNT_W  = FD_CNT_W,
    parameter int FRAC_W = FD_FRAC_W,
    parameter int DEF_N  = 8,
    parameter int DEF_F  = 7,
    parameter int DEF_D  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_n,
    input  logic [FRAC_W-1:0] cfg_f,
    input  logic [FRAC_W-1:0] cfg_d,
    output logic              cfg_err,
    output logic              div_clk,
    output logic              period_start,
    output logic [CNT_W:0]    period_len,
    output logic              running
);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    n_q, pend_n, eff_n;
    logic [FRAC_W-1:0]   f_q, d_q, acc, pend_f, pend_d;
    logic [FRAC_W-1:0]   eff_f, eff_d, eff_acc;
    logic [FRAC_W:0]     sum, diff;
    logic [CNT_W:0]      len_q;
    logic                pend_vld, err_q;
    logic                xfer, legal, apply, carry;
    logic                start_ev, to_idle, last_cycle;

    assign cfg_ready  = !pend_vld;
    assign cfg_err    = err_q;
    assign period_len = len_q;
    assign running    = (state != IDLE);

    assign xfer  = cfg_valid && cfg_ready;
    assign legal = cfg_legal(32'(cfg_n), 32'(cfg_f), 32'(cfg_d));
    // Pending config only lands when no period is in flight or at its last cycle.
    assign apply = pend_vld && ((state == IDLE) || last_cycle);

    assign eff_n   = apply ? pend_n : n_q;
    assign eff_f   = apply ? pend_f : f_q;
    assign eff_d   = apply ? pend_d : d_q;
    assign eff_acc = apply ? '0     : acc;

    // acc < D and F < D, so the sum never exceeds 2D-2 and fits FRAC_W+1 bits.
    assign sum   = {1'b0, eff_acc} + {1'b0, eff_f};
    assign carry = (sum >= {1'b0, eff_d});
    assign diff  = sum - {1'b0, eff_d};

    always_comb begin
        state_nx = state;
        start_ev = 1'b0;
        to_idle  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = RUN;
                    start_ev = 1'b1;
                end
            end
            RUN: begin
                if (last_cycle) begin
                    if (en) begin
                        start_ev = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        to_idle  = 1'b1;
                    end
                end else if (!en) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (last_cycle) begin
                    if (en) begin
                        state_nx = RUN;
                        start_ev = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        to_idle  = 1'b1;
                    end
                end else if (en) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_q      <= CNT_W'(DEF_N);
            f_q      <= FRAC_W'(DEF_F);
            d_q      <= FRAC_W'(DEF_D);
            acc      <= '0;
            len_q    <= '0;
            pend_vld <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= xfer && !legal;

            if (apply) begin
                n_q      <= pend_n;
                f_q      <= pend_f;
                d_q      <= pend_d;
                pend_vld <= 1'b0;
            end else if (xfer && legal) begin
                pend_vld <= 1'b1;
            end

            if (start_ev) begin
                acc   <= carry ? diff[FRAC_W-1:0] : sum[FRAC_W-1:0];
                len_q <= {1'b0, eff_n} + {{CNT_W{1'b0}}, carry};
            end else if (to_idle || apply) begin
                acc <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer && legal) begin
            pend_n <= cfg_n;
            pend_f <= cfg_f;
            pend_d <= cfg_d;
        end
    end

    frac_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (running),
        .load         (start_ev),
        .len          (len_q),
        .div_clk      (div_clk),
        .period_start (period_start),
        .last_cycle   (last_cycle)
    );

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Directed bench for frac_div_ctrl: period sequencing, config handshake, stop/resume, reset.
module tb_frac_div_ctrl;

    localparam int CNT_W  = 8;
    localparam int FRAC_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [CNT_W-1:0]  cfg_n = '0;
    logic [FRAC_W-1:0] cfg_f = '0;
    logic [FRAC_W-1:0] cfg_d = '0;
    logic              cfg_ready, cfg_err, div_clk, period_start, running;
    logic [CNT_W:0]    period_len;

    int n_vec = 0;
    int n_err = 0;
    int exp_def[10] = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};

    frac_div_ctrl #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W),
        .DEF_N  (8),
        .DEF_F  (7),
        .DEF_D  (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_n        (cfg_n),
        .cfg_f        (cfg_f),
        .cfg_d        (cfg_d),
        .cfg_err      (cfg_err),
        .div_clk      (div_clk),
        .period_start (period_start),
        .period_len   (period_len),
        .running      (running)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        bit found = 1'b0;
        int i = 0;
        while (!found && i < 600) begin
            if (period_start) found = 1'b1;
            else begin
                step();
                i++;
            end
        end
        check_val({tag, "_start_seen"}, int'(found), 1);
    endtask

    // Entered on the negedge of a period_start cycle; leaves on the next one.
    task automatic measure(input string tag, input int exp_len, output int cycles);
        int high;
        cycles = 0;
        high   = 0;
        check_val({tag, "_len"}, int'(period_len), exp_len);
        do begin
            high += int'(div_clk);
            cycles++;
            step();
        end while (!period_start && cycles < 600);
        check_val({tag, "_cyc"}, cycles, exp_len);
`ifndef FRAC_DIV_HALF_DUTY_EN
        check_val({tag, "_high"}, high, exp_len / 2);
`endif
    endtask

    task automatic offer_cfg(input int n, input int f, input int d);
        cfg_valid = 1'b1;
        cfg_n = CNT_W'(n);
        cfg_f = FRAC_W'(f);
        cfg_d = FRAC_W'(d);
        step();
        cfg_valid = 1'b0;
    endtask

`ifdef FRAC_DIV_HALF_DUTY_EN
    task automatic wait_level(input logic lvl, output int units);
        units = 0;
        while (div_clk !== lvl && units < 2000) begin
            #1;
            units++;
        end
    endtask
`endif

    initial begin
        int tot, c;
`ifdef FRAC_DIV_HALF_DUTY_EN
        int u, th, tl;
`endif
        step();
        step();
        check_val("rst_ready", int'(cfg_ready), 1);
        check_val("rst_err", int'(cfg_err), 0);
        check_val("rst_div", int'(div_clk), 0);
        check_val("rst_start", int'(period_start), 0);
        check_val("rst_len", int'(period_len), 0);
        check_val("rst_running", int'(running), 0);

        rst_n = 1'b1;
        step();
        check_val("idle_running", int'(running), 0);
        en = 1'b1;
        step();
        check_val("first_start", int'(period_start), 1);
        check_val("first_running", int'(running), 1);

        tot = 0;
        for (int k = 0; k < 10; k++) begin
            measure($sformatf("def%0d", k), exp_def[k], c);
            tot += c;
        end
        check_val("def_total", tot, 87);

        // acc back at 0 gives the 8-cycle period again
        check_val("p11_len", int'(period_len), 8);
        step();
        step();
        check_val("ill_ready_pre", int'(cfg_ready), 1);
        offer_cfg(8, 10, 10);
        check_val("ill_fd_err", int'(cfg_err), 1);
        check_val("ill_fd_ready", int'(cfg_ready), 1);
        step();
        check_val("ill_err_clear", int'(cfg_err), 0);
        offer_cfg(1, 0, 1);
        check_val("ill_n1_err", int'(cfg_err), 1);
        wait_start("p12");
        measure("p12", 9, c);
        measure("p13", 9, c);

        check_val("p14_len", int'(period_len), 8);
        repeat (3) step();
        offer_cfg(5, 0, 1);
        check_val("pend_ready", int'(cfg_ready), 0);
        step();
        check_val("pend_ready2", int'(cfg_ready), 0);
        wait_start("n5");
        check_val("applied_ready", int'(cfg_ready), 1);
        for (int k = 0; k < 3; k++) measure($sformatf("n5_%0d", k), 5, c);

        step();
        offer_cfg(8, 7, 10);
        wait_start("rc");
        measure("rc0", 8, c);
        check_val("stop_len", int'(period_len), 9);
        repeat (3) step();
        en = 1'b0;
        repeat (5) step();
        check_val("stop_last_running", int'(running), 1);
        step();
        check_val("stop_running", int'(running), 0);
        check_val("stop_div", int'(div_clk), 0);
        check_val("stop_start", int'(period_start), 0);
        repeat (3) step();
        check_val("idle_div", int'(div_clk), 0);
        check_val("idle_running2", int'(running), 0);
        en = 1'b1;
        step();
        check_val("resume_start", int'(period_start), 1);
        check_val("resume_len_acc0", int'(period_len), 8);

        repeat (4) step();
        check_val("pre_rst_div", int'(div_clk), 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_div", int'(div_clk), 0);
        check_val("mid_rst_running", int'(running), 0);
        check_val("mid_rst_len", int'(period_len), 0);
        check_val("mid_rst_start", int'(period_start), 0);
        check_val("mid_rst_ready", int'(cfg_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_start("post_rst");
        measure("post0", 8, c);
        measure("post1", 9, c);

        step();
        offer_cfg(255, 1, 2);
        wait_start("max");
        measure("max0", 255, c);
        measure("max1", 256, c);
        check_val("max2_len", int'(period_len), 255);

`ifdef FRAC_DIV_HALF_DUTY_EN
        step();
        offer_cfg(9, 0, 1);
        wait_start("hd");
        check_val("hd_len", int'(period_len), 9);
        wait_level(1'b1, u);
        wait_level(1'b0, th);
        wait_level(1'b1, tl);
        check_val("hd_high_units", th, 45);
        check_val("hd_low_units", tl, 45);
`endif

        en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/frac_div_ctrl.md
Name: frac_div_ctrl

Overview:
Runtime-configurable fractional clock-divider controller that produces an average division ratio of N + F/D.
- Per output period, a first-order accumulator chooses between an N-cycle and an (N+1)-cycle period.
- It drives a small period core that generates div_clk.
- Sits between the register/config interface and clock consumers that need non-integer ratios, e.g. 8.7.
- Reconfiguration takes effect only on period boundaries, so no runt pulses occur.

Parameters:
- CNT_W, 8, width of integer divisor N (period length up to 2^CNT_W).
- FRAC_W, 4, width of F and D.
- DEF_N, 8, integer divisor loaded at reset.
- DEF_F, 7, fractional numerator loaded at reset.
- DEF_D, 10, fractional denominator loaded at reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run request (level).
- cfg_valid  in  1  new config offered.
- cfg_ready  out  1  controller can accept config.
- cfg_n  in  CNT_W  integer divisor N.
- cfg_f  in  FRAC_W  fractional numerator F.
- cfg_d  in  FRAC_W  fractional denominator D.
- cfg_err  out  1  one-cycle pulse: accepted config was illegal and was dropped.
- div_clk  out  1  divided clock.
- period_start  out  1  pulse in the first cycle of each output period.
- period_len  out  CNT_W+1  length of the current period (N or N+1).
- running  out  1  high in RUN and STOP.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; active config = DEF_N/DEF_F/DEF_D; acc=0; no pending config.
  - cfg_ready=1; all other outputs 0; period_len=0.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - Legal iff N>=2, D>=1, F<D.
  - Illegal: transfer still completes; cfg_err pulses the next cycle; nothing is stored.
  - Legal: stored as pending and cfg_ready drops until the pending config is applied.
- Applying pending config:
  - In IDLE: applied the cycle after transfer.
  - In RUN/STOP: applied in the last cycle of the current period (cnt==period_len-1). acc clears to 0 and the next period uses the new config.
  - A transfer in a boundary cycle applies at the following boundary.
- States:
  - IDLE -> RUN: when en=1. period_start is asserted the next cycle.
  - RUN -> STOP: when en=0. The current period always completes.
  - STOP -> IDLE: at the period boundary. acc cleared; div_clk low.
  - STOP -> RUN: if en returns to 1 before the boundary, with no gap.
- Period selection at each period start:
  - s = acc + F, width FRAC_W+1, no overflow because s < 2D.
  - If s >= D: len=N+1, acc=s-D. Otherwise len=N, acc=s.
  - period_len is registered and valid from the period_start cycle.
- Core counter:
  - cnt runs 0..len-1; period_start = (cnt==0 in RUN/STOP).
  - div_clk is registered: high while cnt < len>>1, low otherwise, with one clk latency from cnt.
  - Odd lengths: high (len-1)/2 cycles, low (len+1)/2 cycles.
- Boundaries:
  - en toggling within one period has no effect on that period.
  - F=0 gives an integer divide by N.
  - N = 2^CNT_W - 1 with carry gives len = 2^CNT_W, which must be representable in period_len.
- Reset mid-period: async clear to reset values; div_clk goes low immediately.

Optional Feature:
- Macro: FRAC_DIV_HALF_DUTY_EN.
- Defined: the core adds a negedge-clk flop holding the high phase for an extra half cycle on odd periods, so every period has exactly 50% duty: high = len/2 clk periods, and div_clk = posedge_flop | negedge_flop.
- Undefined: posedge-only logic; duty as above, fully synchronous and scan-friendly.

Decomposition:
- Package frac_div_pkg:
  - CNT_W/FRAC_W defaults.
  - State enum {IDLE, RUN, STOP}.
  - Function cfg_legal(n, f, d).
- Sub-module frac_div_core:
  - Inputs: len, load pulse.
  - Contains the cycle counter, duty comparator and, under FRAC_DIV_HALF_DUTY_EN, the negedge flop.
  - Outputs: div_clk, period_start, last_cycle.
- frac_div_ctrl holds the FSM, accumulator and config handshake.

Test Plan:
- Defaults 8/7/10, en=1 for 10 periods -> period_len sequence 8,9,9,8,9,9,8,9,9,9; 87 clk total; acc returns to 0.
- cfg 5/0/1 mid-period -> cfg_ready low until the boundary; all later periods len=5; no div_clk pulse shorter than 2 clk.
- Illegal cfg F=10, D=10 -> cfg_err one pulse one cycle after transfer; period sequence unchanged; cfg_ready stays 1.
- en=0 at cnt=3 of a 9-cycle period -> period completes, running falls at the boundary, div_clk held 0; en=1 again -> period_start the next cycle with acc=0.
- rst_n asserted at cnt=4 -> all outputs 0 asynchronously; after release, defaults reload and the first period is len 8.
- With FRAC_DIV_HALF_DUTY_EN, N=9, F=0 -> div_clk high 4.5 clk and low 4.5 clk every period.
